// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment display. A single shared decoder is fed from a load-strobed
// shadow copy of the display value. Digits are scanned at a programmable
// refresh rate. Supports hex glyphs, per-digit blanking and blinking,
// leading-zero suppression and decimal points.
//
// Load interface: load is a single-cycle strobe with no back-pressure. Every
// cycle with load=1 captures digits_in, dp_in, blank_mask, blink_mask,
// hex_mode and lz_en into the shadow. Outside a load those inputs are ignored.
// The new value reaches the pins one cycle after capture.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    hex_mode,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Scan state
  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Shadow copy of the display value
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    hex_q;
  logic                    lz_q;

  // Per-slot combinational view
  logic                  refresh_tc;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] cur_sel;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;

  // Active-low {g,f,e,d,c,b,a} glyph for one nibble. Letters appear only in hex mode.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = hex ? 7'b0001000 : 7'b1111111;
      4'hB: s = hex ? 7'b0000011 : 7'b1111111;
      4'hC: s = hex ? 7'b1000110 : 7'b1111111;
      4'hD: s = hex ? 7'b0100001 : 7'b1111111;
      4'hE: s = hex ? 7'b0000110 : 7'b1111111;
      4'hF: s = hex ? 7'b0001110 : 7'b1111111;
    endcase
    return s;
  endfunction

  // Digit k>0 is suppressed when it and every higher nibble are zero.
  // Digit 0 is never suppressed.
  function automatic logic [NUM_DIGITS-1:0] lz_suppress(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic                    en
  );
    logic [NUM_DIGITS-1:0] s;
    logic                  zero_run;
    s = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (d[4*k +: 4] == 4'd0);
      s[k] = en & zero_run;
    end
    return s;
  endfunction

  assign refresh_tc = (refresh_cnt == CNT_LAST);
  assign frame_end  = refresh_tc && (idx == IDX_LAST);

  // Leading-zero suppression over the whole shadow value
  always_comb begin
    suppress = lz_suppress(digits_q, lz_q);
  end

  // Select the active digit's nibble and dp, and work out whether its slot stays dark
  always_comb begin
    cur_nib  = 4'd0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    cur_sel  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib    = digits_q[4*k +: 4];
        cur_dp     = dp_q[k];
        cur_dark   = blank_q[k] | (blink_q[k] & blink_phase) | suppress[k];
        cur_sel[k] = 1'b1;
      end
    end
  end

  // Refresh counter, scan index and blink timing; load never touches these
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (refresh_tc) begin
        refresh_cnt <= '0;
        idx         <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      if (frame_end) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Shadow capture on the load strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      hex_q    <= 1'b0;
      lz_q     <= 1'b0;
    end else if (load) begin
      digits_q <= digits_in;
      dp_q     <= dp_in;
      blank_q  <= blank_mask;
      blink_q  <= blink_mask;
      hex_q    <= hex_mode;
      lz_q     <= lz_en;
    end
  end

  // Registered pin drivers; a dark slot leaves every anode and cathode off
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (cur_dark) begin
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~cur_sel;
      seg <= decode(cur_nib, hex_q);
      dp  <= ~cur_dp;
    end
  end

endmodule
